// File: rtl/conv_stream_feeder_if.sv
// AXI4-Stream bundle carrying the filter and image packets out of the feeder.
interface conv_stream_feeder_if #(
  parameter int DATA_W = 16
);
  logic                  M_AXIS_TVALID;
  logic [DATA_W-1:0]     M_AXIS_TDATA;
  logic [DATA_W/8-1:0]   M_AXIS_TKEEP;
  logic                  M_AXIS_TLAST;
  logic                  M_AXIS_TREADY;

  modport master (
    output M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST,
    input  M_AXIS_TREADY
  );

  modport slave (
    input  M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST,
    output M_AXIS_TREADY
  );
endinterface

// File: rtl/conv_stream_feeder.sv
// Reads a filter then an image from 1-cycle memory and streams them as two AXI4-Stream packets.
// Latency: start -> first read 1 cycle, first TVALID 3 cycles; one beat per cycle under TREADY=1.
// Backpressure: reads issue only while FIFO+in-flight can absorb them; TDATA/TLAST hold while stalled.
module conv_stream_feeder #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int FILT_LEN = 9
) (
  input  logic              M_AXIS_ACLK,
  input  logic              M_AXIS_ARESETN,
  input  logic              start,
  input  logic [ADDR_W-1:0] filt_base,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [31:0]       img_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  conv_stream_feeder_if.master m_axis,
  output logic              busy,
  output logic              done,
  output logic              len_err
);

  typedef enum logic [1:0] {IDLE, FILT, IMG, DRAIN} state_t;

  // Assert asynchronously, release two edges after ARESETN rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) rst_sync_q <= 2'b00;
    else                 rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_t            state_q;
  logic [31:0]       idx_q;
  logic [31:0]       img_len_q;
  logic [ADDR_W-1:0] filt_base_q;
  logic [ADDR_W-1:0] img_base_q;
  logic              busy_q, done_q, len_err_q;
  logic              inflight_q, tag_q;

  logic [DATA_W:0]   fifo_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        cnt_q;

  logic              pop, push, rd_last, head_vld;
  logic [2:0]        occ_d;

  assign head_vld = (cnt_q != 2'd0);
  assign pop      = head_vld && m_axis.M_AXIS_TREADY;
  assign push     = inflight_q;

  // Entries that will be held next cycle if nothing new is issued now.
  assign occ_d     = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign mem_rd_en = ((state_q == FILT) || (state_q == IMG)) && (occ_d <= 3'd1);
  assign mem_addr  = ((state_q == FILT) ? filt_base_q : img_base_q) + idx_q[ADDR_W-1:0];
  assign rd_last   = ((state_q == FILT) && (idx_q == 32'(FILT_LEN - 1))) ||
                     ((state_q == IMG)  && (idx_q == img_len_q - 32'd1));

  assign m_axis.M_AXIS_TVALID = head_vld;
  assign m_axis.M_AXIS_TDATA  = fifo_q[rd_ptr_q][DATA_W-1:0];
  assign m_axis.M_AXIS_TLAST  = head_vld && fifo_q[rd_ptr_q][DATA_W];
  assign m_axis.M_AXIS_TKEEP  = '1;

  assign busy    = busy_q;
  assign done    = done_q;
  assign len_err = len_err_q;

  always_ff @(posedge M_AXIS_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {tag_q, mem_rdata};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 32'd0;
      img_len_q   <= 32'd0;
      filt_base_q <= '0;
      img_base_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
      inflight_q  <= 1'b0;
      tag_q       <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
      inflight_q <= mem_rd_en;
      tag_q      <= mem_rd_en && rd_last;
      case (state_q)
        IDLE: begin
          if (start) begin
            if ((img_len == 32'd0) || ((img_len % 32'd3) != 32'd0)) begin
              len_err_q <= 1'b1;
            end else begin
              filt_base_q <= filt_base;
              img_base_q  <= img_base;
              img_len_q   <= img_len;
              idx_q       <= 32'd0;
              busy_q      <= 1'b1;
              state_q     <= FILT;
            end
          end
        end
        FILT: begin
          if (mem_rd_en) begin
            if (rd_last) begin
              idx_q   <= 32'd0;
              state_q <= IMG;
            end else begin
              idx_q <= idx_q + 32'd1;
            end
          end
        end
        IMG: begin
          if (mem_rd_en) begin
            if (rd_last) state_q <= DRAIN;
            else         idx_q   <= idx_q + 32'd1;
          end
        end
        DRAIN: begin
          // Filter TLAST has always left the FIFO before DRAIN, so any TLAST here ends the image.
          if (pop && m_axis.M_AXIS_TLAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed table-driven bench for conv_stream_feeder with a behavioural 1-cycle memory.
module tb_conv_stream_feeder;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] filt_base, img_base;
  logic [31:0]   img_len;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          busy, done, len_err;
  logic          tready;

  always #5 clk = ~clk;

  conv_stream_feeder_if #(.DATA_W(DW)) axis ();
  assign axis.M_AXIS_TREADY = tready;

  conv_stream_feeder #(.ADDR_W(AW), .DATA_W(DW), .FILT_LEN(9)) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .start          (start),
    .filt_base      (filt_base),
    .img_base       (img_base),
    .img_len        (img_len),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .m_axis         (axis),
    .busy           (busy),
    .done           (done),
    .len_err        (len_err)
  );

  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct {
    logic [AW-1:0] fb;
    logic [AW-1:0] ib;
    logic [31:0]   len;
    int            rmode;     // 0 ready, 1 low cycles 5..9, 2 random
    int            restart;   // cycle of a second start pulse, -1 none
    int            exp_beats;
    int            exp_done;  // -1: not a fixed cycle
    int            exp_lerr;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cur_vec = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL v%0d %s: got %0d expected %0d", cur_vec, nm, act, exp);
    end
  endtask

  function automatic logic next_ready(input int mode, input int t);
    if (mode == 1) return !(t >= 5 && t <= 9);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic run_vec(input vec_t v);
    int beats = 0, derr = 0, nlast = 0, first = -1, done_cyc = -1, ndone = 0;
    int nlerr = 0, lerr_cyc = -1, busy_rise = -1, busy_fall = -1;
    int nrd = 0, maxout = 0, holdv = 0, data7 = -1;
    logic pv = 1'b0, pr = 1'b0;
    logic [DW:0] pdat = '0;
    logic [DW:0] expw;
    logic [AW-1:0] a;
    int k;

    @(posedge clk); #1;
    filt_base = v.fb; img_base = v.ib; img_len = v.len; start = 1'b1;
    tready = next_ready(v.rmode, 0);
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (mem_rd_en) nrd++;
      if (busy && busy_rise < 0) busy_rise = t;
      if (!busy && busy_rise >= 0 && busy_fall < 0) busy_fall = t;
      if (done) begin ndone++; done_cyc = t; end
      if (len_err) begin nlerr++; lerr_cyc = t; end
      if (pv && !pr && (!axis.M_AXIS_TVALID || {axis.M_AXIS_TLAST, axis.M_AXIS_TDATA} !== pdat)) holdv++;
      if (axis.M_AXIS_TVALID && first < 0) first = t;
      if (t == 7) data7 = int'(axis.M_AXIS_TDATA);
      if (axis.M_AXIS_TVALID && tready) begin
        k = beats;
        if (k < 9) begin
          a = v.fb + AW'(k);
          expw = {k == 8, mem[a]};
        end else begin
          a = v.ib + AW'(k - 9);
          expw = {(k - 9) == int'(v.len) - 1, mem[a]};
        end
        if ({axis.M_AXIS_TLAST, axis.M_AXIS_TDATA} !== expw) derr++;
        if (axis.M_AXIS_TLAST) nlast++;
        beats++;
      end
      if (nrd - beats > maxout) maxout = nrd - beats;
      pv = axis.M_AXIS_TVALID; pr = tready; pdat = {axis.M_AXIS_TLAST, axis.M_AXIS_TDATA};
      if (done_cyc >= 0 && t > done_cyc + 2) break;
      if (v.exp_lerr != 0 && t >= 15) break;
      @(posedge clk); #1;
      start = 1'b0;
      if (t + 1 == v.restart) begin
        start = 1'b1; img_len = 32'd4; filt_base = 16'h0000; img_base = 16'h0000;
      end
      tready = next_ready(v.rmode, t + 1);
    end
    start = 1'b0; tready = 1'b1;

    chk("beats", beats, v.exp_beats);
    chk("data_or_tlast_errors", derr, 0);
    chk("tlast_count", nlast, (v.exp_beats > 0) ? 2 : 0);
    chk("first_tvalid_cycle", first, (v.exp_beats > 0) ? 3 : -1);
    chk("done_pulses", ndone, (v.exp_lerr != 0) ? 0 : 1);
    if (v.exp_done >= 0) begin
      chk("done_cycle", done_cyc, v.exp_done);
      chk("busy_fall_cycle", busy_fall, v.exp_done);
    end else if (v.exp_lerr == 0) begin
      chk("busy_fall_at_done", busy_fall, done_cyc);
    end
    chk("busy_rise_cycle", busy_rise, (v.exp_lerr != 0) ? -1 : 1);
    chk("len_err_pulses", nlerr, v.exp_lerr);
    if (v.exp_lerr != 0) chk("len_err_cycle", lerr_cyc, 1);
    chk("reads_issued", nrd, (v.exp_lerr != 0) ? 0 : 9 + int'(v.len));
    chk("outstanding_le_2", int'(maxout <= 2), 1);
    chk("hold_violations", holdv, 0);
    if (v.rmode == 1) chk("stalled_tdata", data7, 3);
  endtask

  vec_t vecs [7];
  vec_t post;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = DW'(i) ^ 16'h5A5A;
    for (int i = 0; i < 9; i++)  mem[16'h0100 + i] = DW'(i + 1);
    for (int i = 0; i < 64; i++) mem[16'h0200 + i] = DW'(100 + i);

    //           fb        ib        len    mode rst beats done lerr
    vecs[0] = '{16'h0100, 16'h0200, 32'd9,  0, -1, 18, 21, 0};
    vecs[1] = '{16'h0100, 16'h0200, 32'd9,  1, -1, 18, 26, 0};
    vecs[2] = '{16'h0100, 16'h0200, 32'd48, 2, -1, 57, -1, 0};
    vecs[3] = '{16'h0100, 16'h0200, 32'd10, 0, -1, 0,  -1, 1};
    vecs[4] = '{16'h0100, 16'h0200, 32'd0,  0, -1, 0,  -1, 1};
    vecs[5] = '{16'hFFFC, 16'hFFFE, 32'd6,  0, -1, 15, 18, 0};
    vecs[6] = '{16'h0100, 16'h0200, 32'd9,  0, 13, 18, 21, 0};
    post    = '{16'h0100, 16'h0200, 32'd3,  0, -1, 12, 15, 0};

    rst_n = 1'b0; start = 1'b0; tready = 1'b1;
    filt_base = '0; img_base = '0; img_len = '0;
    #12;
    chk("reset_tvalid", int'(axis.M_AXIS_TVALID), 0);
    chk("reset_busy", int'(busy), 0);
    #11 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_reset_tvalid", int'(axis.M_AXIS_TVALID), 0);
    chk("post_reset_tlast", int'(axis.M_AXIS_TLAST), 0);
    chk("post_reset_rd_en", int'(mem_rd_en), 0);
    chk("post_reset_done", int'(done), 0);
    chk("post_reset_len_err", int'(len_err), 0);
    chk("tkeep_all_ones", int'(axis.M_AXIS_TKEEP), 3);

    for (int i = 0; i < 7; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
      repeat (3) @(posedge clk);
    end

    // Asynchronous reset mid-image, then a short clean run.
    cur_vec = 7;
    @(posedge clk); #1;
    filt_base = 16'h0100; img_base = 16'h0200; img_len = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrun_reset_tvalid", int'(axis.M_AXIS_TVALID), 0);
    chk("midrun_reset_busy", int'(busy), 0);
    chk("midrun_reset_rd_en", int'(mem_rd_en), 0);
    chk("midrun_reset_tlast", int'(axis.M_AXIS_TLAST), 0);
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    cur_vec = 8;
    run_vec(post);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
